// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for DIV/DIVU with HI/LO write-back
// One quotient bit per RUN cycle; results are registered and forced to zero while not valid.
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        signed_div,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cancel,
   input  logic        ack,
   output logic        busy,
   output logic        valid,
   output logic [31:0] hi,
   output logic        hi_wen,
   output logic [31:0] lo,
   output logic        lo_wen
);

   typedef enum logic [1:0] {IDLE, ZERO, RUN, DONE} state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic [63:0] p;
   logic [31:0] dm;
   logic [31:0] a_raw;
   logic        neg_q;
   logic        neg_r;
   logic [31:0] res_hi;
   logic [31:0] res_lo;

   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [32:0] diff;
   logic [63:0] p_next;
   logic [31:0] q_fin;
   logic [31:0] r_fin;

   always_comb begin
      a_mag = (signed_div && a[31]) ? (~a + 32'd1) : a;
      b_mag = (signed_div && b[31]) ? (~b + 32'd1) : b;
      // 33-bit compare: the shifted remainder can reach 2*dm-1, which overflows 32 bits
      diff  = p[63:31] - {1'b0, dm};
      if (!diff[32])
         p_next = {diff[31:0], p[30:0], 1'b1};
      else
         p_next = {p[62:0], 1'b0};
      q_fin = neg_q ? (~p_next[31:0] + 32'd1) : p_next[31:0];
      r_fin = neg_r ? (~p_next[63:32] + 32'd1) : p_next[63:32];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= 6'd0;
         p      <= 64'd0;
         dm     <= 32'd0;
         a_raw  <= 32'd0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         res_hi <= 32'd0;
         res_lo <= 32'd0;
         valid  <= 1'b0;
      end else if (cancel) begin
         state  <= IDLE;
         cnt    <= 6'd0;
         res_hi <= 32'd0;
         res_lo <= 32'd0;
         valid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_raw <= a;
                  neg_q <= signed_div & (a[31] ^ b[31]);
                  neg_r <= signed_div & a[31];
                  p     <= {32'd0, a_mag};
                  dm    <= b_mag;
                  cnt   <= 6'd0;
                  state <= (b == 32'd0) ? ZERO : RUN;
               end
            end
            ZERO: begin
               res_lo <= 32'hFFFF_FFFF;
               res_hi <= a_raw;
               valid  <= 1'b1;
               state  <= DONE;
            end
            RUN: begin
               p   <= p_next;
               cnt <= cnt + 6'd1;
               if (cnt == 6'd31) begin
                  res_lo <= q_fin;
                  res_hi <= r_fin;
                  valid  <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (ack) begin
                  res_hi <= 32'd0;
                  res_lo <= 32'd0;
                  valid  <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy   = (state == ZERO) || (state == RUN) ||
                   ((state == IDLE) && start && !cancel);
   assign hi     = res_hi;
   assign lo     = res_lo;
   assign hi_wen = valid;
   assign lo_wen = valid;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
// A plain-arithmetic model supplies expected HI/LO; one negedge process compares every cycle.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        signed_div;
   logic [31:0] a;
   logic [31:0] b;
   logic        cancel;
   logic        ack;
   logic        busy;
   logic        valid;
   logic [31:0] hi;
   logic        hi_wen;
   logic [31:0] lo;
   logic        lo_wen;

   int checks = 0;
   int errors = 0;

   logic        cmp_en = 1'b0;
   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;

   always #5 clk = ~clk;

   div_unit dut (
      .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
      .a(a), .b(b), .cancel(cancel), .ack(ack),
      .busy(busy), .valid(valid), .hi(hi), .hi_wen(hi_wen),
      .lo(lo), .lo_wen(lo_wen)
   );

   function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
      int sx;
      int sy;
      if (y == 32'd0)
         return {x, 32'hFFFF_FFFF};
      if (!s)
         return {x % y, x / y};
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
         return {32'd0, 32'h8000_0000};
      sx = $signed(x);
      sy = $signed(y);
      return {32'(sx % sy), 32'(sx / sy)};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && cmp_en) begin
         check("wen_eq_valid", {62'd0, hi_wen, lo_wen}, {62'd0, valid, valid});
         if (valid)
            check("result", {hi, lo}, {exp_hi, exp_lo});
         else
            check("zero_when_idle", {hi, lo}, 64'd0);
      end
   end

   // hold: DONE cycles with ack=0 (start pulsed meanwhile); poke: start pulse mid-RUN
   task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                         input int hold, input bit poke);
      int lat;
      {exp_hi, exp_lo} = model(x, y, s);
      @(posedge clk); #1;
      a = x; b = y; signed_div = s; start = 1'b1; ack = (hold == 0);
      #1 check("busy_comb_start", {63'd0, busy}, 64'd1);
      @(posedge clk); #1;
      start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0000_0001; signed_div = ~s;
      lat = 0;
      while (!valid && lat < 100) begin
         check("busy_while_running", {63'd0, busy}, 64'd1);
         @(posedge clk); #1;
         lat++;
         start = (poke && lat == 5);
      end
      start = 1'b0;
      check("latency", 64'(lat), (y == 32'd0) ? 64'd1 : 64'd32);
      check("busy_done", {63'd0, busy}, 64'd0);
      for (int i = 0; i < hold; i++) begin
         start = (i == 2);
         @(posedge clk); #1;
         check("hold_valid", {63'd0, valid}, 64'd1);
      end
      start = 1'b0;
      ack = 1'b1;
      @(posedge clk); #1;
      check("idle_after_ack", {62'd0, valid, busy}, 64'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; signed_div = 1'b0; a = 32'd0; b = 32'd0;
      cancel = 1'b0; ack = 1'b0;

      check("model_100_7", model(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
      check("model_m7_2", model(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      check("model_ovf", model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'd0, 32'h8000_0000});
      check("model_div0", model(32'd5, 32'd0, 1'b0), {32'd5, 32'hFFFF_FFFF});
      check("model_9_3", model(32'd9, 32'd3, 1'b0), {32'd0, 32'd3});

      @(posedge clk); @(posedge clk); #1;
      check("reset_outputs", {hi, lo}, 64'd0);
      check("reset_flags", {60'd0, busy, valid, hi_wen, lo_wen}, 64'd0);
      rst = 1'b0;
      cmp_en = 1'b1;

      run_op(32'd100, 32'd7, 1'b0, 0, 1'b0);
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, 1'b0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
      run_op(32'd5, 32'd0, 1'b0, 0, 1'b0);
      run_op(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 0, 1'b1);
      run_op(32'd7, 32'hFFFF_FFFD, 1'b1, 5, 1'b0);
      run_op(32'h1234_5678, 32'd0, 1'b1, 0, 1'b0);
      run_op(32'd9, 32'd3, 1'b0, 0, 1'b0);

      // cancel at RUN iteration 10
      @(posedge clk); #1;
      a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1 cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      check("cancel_idle", {62'd0, busy, valid}, 64'd0);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (valid) check("cancel_no_valid", {63'd0, valid}, 64'd0);
      end
      check("cancel_still_quiet", {62'd0, busy, valid}, 64'd0);

      // cancel wins over start in IDLE
      @(posedge clk); #1;
      a = 32'd4; b = 32'd2; start = 1'b1; cancel = 1'b1;
      #1 check("cancel_beats_start_busy", {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
      start = 1'b0; cancel = 1'b0;
      check("cancel_beats_start", {63'd0, busy}, 64'd0);

      run_op(32'd9, 32'd3, 1'b0, 0, 1'b0);

      // reset at iteration 20
      @(posedge clk); #1;
      a = 32'd77; b = 32'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #1 rst = 1'b1; ack = 1'b1; cancel = 1'b0;
      @(posedge clk); #1;
      check("mid_run_reset_data", {hi, lo}, 64'd0);
      check("mid_run_reset_flags", {60'd0, busy, valid, hi_wen, lo_wen}, 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (valid) check("reset_no_valid", {63'd0, valid}, 64'd0);
      end

      run_op(32'd100, 32'd7, 1'b0, 0, 1'b0);
      run_op(32'h8000_0000, 32'd3, 1'b1, 2, 1'b0);

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The interface SHALL have one clock, clk, and a synchronous, active-high reset, rst. These ports SHALL be listed first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new divide; sampled only in IDLE.
REQ-005 signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; latched with start.
REQ-006 a  input  32  dividend; latched with start.
REQ-007 b  input  32  divisor; latched with start.
REQ-008 cancel  input  1  exception/flush; aborts any operation.
REQ-009 ack  input  1  pipeline consumed the result (MEM stage advancing, no exception).
REQ-010 busy  output  1  stall request to the pipeline.
REQ-011 valid  output  1  result present on hi/lo.
REQ-012 hi  output  32  remainder, to the HI/LO register write port.
REQ-013 hi_wen  output  1  HI write enable; equals valid.
REQ-014 lo  output  32  quotient, to the HI/LO register write port.
REQ-015 lo_wen  output  1  LO write enable; equals valid.

Function
REQ-016 The FSM SHALL have the states IDLE, ZERO, RUN and DONE, with a 6-bit iteration counter.
REQ-017 IDLE transitions:
- start=1, cancel=0, b!=0 -> RUN; latch operands and signed_div; counter=0.
- start=1, cancel=0, b==0 -> ZERO.
- otherwise stay in IDLE.
REQ-018 In RUN, each cycle SHALL perform one radix-2 restoring shift/subtract step on 32-bit magnitudes (64-bit partial remainder) and increment the counter.
REQ-019 After the 32nd RUN cycle the FSM SHALL go to DONE; a start sampled at edge N yields valid=1 in cycle N+33.
REQ-020 ZERO SHALL last one cycle and then go to DONE with lo=32'hFFFFFFFF and hi=a (the latched dividend, unmodified).
REQ-021 Signed mode SHALL divide |a| by |b| and then apply the signs:
- quotient negated iff a[31]^b[31];
- remainder negated iff a[31].
REQ-022 Signed 32'h80000000 / 32'hFFFFFFFF SHALL produce lo=32'h80000000, hi=0 (wrap, no trap).
REQ-023 In DONE, valid=hi_wen=lo_wen=1, and hi/lo SHALL be held stable until ack=1; DONE with ack=1 -> IDLE on the next edge.
REQ-024 busy SHALL be 1 in ZERO and RUN, 1 combinationally in IDLE when start=1 and cancel=0, and 0 in DONE.
REQ-025 A start in RUN, ZERO or DONE SHALL be ignored and SHALL NOT disturb the latched operands.
REQ-026 cancel=1 in any state SHALL force IDLE on the next edge with valid=0; in IDLE, cancel SHALL win over start.
REQ-027 valid SHALL never be asserted for a cancelled operation.
REQ-028 A new start in the cycle after DONE+ack SHALL be accepted normally.
REQ-029 hi and lo SHALL read 0 whenever valid=0.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, clear the counter and the operand/result registers, and drive busy=valid=hi_wen=lo_wen=0, hi=lo=0.
REQ-031 Reset SHALL take priority over start, cancel and ack, including mid-RUN; no partial result is ever presented.

Verification
REQ-032 Unsigned: a=100, b=7, start one cycle, ack=1 -> busy high for 33 cycles; valid at N+33 with lo=14, hi=2; IDLE next cycle.
REQ-033 Signed: a=32'hFFFFFFF9 (-7), b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); and a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-034 Divide by zero: a=5, b=0 -> ZERO, then valid at N+2 with lo=32'hFFFFFFFF, hi=5.
REQ-035 Cancel at RUN iteration 10 -> next cycle IDLE, busy=0, valid stays 0; a subsequent start with a=9, b=3 returns lo=3, hi=0.
REQ-036 Hold and restart:
- ack=0 for 5 cycles in DONE -> valid, hi and lo stable; a start pulsed during DONE is ignored.
- rst at iteration 20 -> all outputs 0 on the next cycle.
